// File: rtl/decoder_bist_pkg.sv
// decoder_bist_pkg: shared state encoding and widths for the 4x16 decoder BIST controller.
package decoder_bist_pkg;
  localparam int CODE_W    = 4;
  localparam int NUM_CODES = 16;
  localparam int CNT_W     = 5;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;
endpackage

// File: rtl/decoder_bist_cmp.sv
// decoder_bist_cmp: expected one-hot word, mismatch flag and (with DECODER_BIST_ONEHOT_CHECK_EN) one-hot check.
module decoder_bist_cmp
  import decoder_bist_pkg::*;
(
  input  logic [CODE_W-1:0]    code,
  input  logic [NUM_CODES-1:0] response,
  output logic [NUM_CODES-1:0] expected,
  output logic                 mismatch
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
  , output logic               onehot_ok
`endif
);
  always_comb begin
    expected = {{(NUM_CODES-1){1'b0}}, 1'b1} << code;
    mismatch = response !== expected;
  end
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
  assign onehot_ok = (response != '0) && ((response & (response - 1'b1)) == '0);
`endif
endmodule

// File: rtl/decoder_bist_ctrl.sv
// decoder_bist_ctrl: walks all 16 codes through a 4x16 decoder and records pass/fail results.
// Define DECODER_BIST_ONEHOT_CHECK_EN to count responses that are not exactly one-hot.
module decoder_bist_ctrl
  import decoder_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [CODE_W-1:0]    d_in_o,
  input  logic [NUM_CODES-1:0] d_out_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_CODES-1:0] fail_mask,
  output logic [CNT_W-1:0]     fail_count,
  output logic [CODE_W-1:0]    first_fail_code,
  output logic                 first_fail_valid,
  output logic [CNT_W-1:0]     onehot_err_count
);
  localparam logic [3:0] LAST_WAIT = 4'(SETTLE_CYCLES - 1);
  state_e               state_q, state_d;
  logic [CODE_W-1:0]    code_q, code_d, ffc_q, ffc_d;
  logic [3:0]           wait_q, wait_d;
  logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d, ffv_q, ffv_d;
  logic [NUM_CODES-1:0] mask_q, mask_d, expected;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mismatch;
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
  logic                 onehot_ok;
  logic [CNT_W-1:0]     oh_q, oh_d;
`endif
  decoder_bist_cmp u_cmp (
    .code(code_q),
    .response(d_out_i),
    .expected(expected),
    .mismatch(mismatch)
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
    , .onehot_ok(onehot_ok)
`endif
  );
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    ffc_d   = ffc_q;
    ffv_d   = ffv_q;
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
    oh_d    = oh_q;
`endif
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = SETTLE;
        code_d  = '0;
        wait_d  = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        mask_d  = '0;
        cnt_d   = '0;
        ffc_d   = '0;
        ffv_d   = 1'b0;
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
        oh_d    = '0;
`endif
      end
      SETTLE: begin
        wait_d  = wait_q + 1'b1;
        state_d = (wait_q == LAST_WAIT) ? CHECK : SETTLE;
      end
      CHECK: begin
        if (mismatch) begin
          mask_d = mask_q | expected;
          cnt_d  = cnt_q + 1'b1;
          ffc_d  = ffv_q ? ffc_q : code_q;
          ffv_d  = 1'b1;
        end
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
        oh_d = onehot_ok ? oh_q : oh_q + 1'b1;
`endif
        if (code_q == CODE_W'(NUM_CODES - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
        end else begin
          state_d = SETTLE;
          code_d  = code_q + 1'b1;
          wait_d  = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      ffc_q   <= '0;
      ffv_q   <= 1'b0;
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
      oh_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ffc_q   <= ffc_d;
      ffv_q   <= ffv_d;
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
      oh_q    <= oh_d;
`endif
    end
  end
  assign d_in_o           = code_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_mask        = mask_q;
  assign fail_count       = cnt_q;
  assign first_fail_code  = ffc_q;
  assign first_fail_valid = ffv_q;
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
  assign onehot_err_count = oh_q;
`else
  assign onehot_err_count = '0;
`endif
endmodule

// File: tb/tb_decoder_bist_ctrl.sv
// tb_decoder_bist_ctrl: two controllers (SETTLE_CYCLES=1 and 3), each driving a table-based decoder model.
module tb_decoder_bist_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] start_w, busy_w, done_w, pass_w, ffv_w;
  logic [1:0][3:0] din_w, ffc_w;
  logic [1:0][15:0] dout_w, mask_w;
  logic [1:0][4:0] cnt_w, oh_w;
  logic [15:0] tbl [2][16];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign dout_w[0] = tbl[0][din_w[0]];
  assign dout_w[1] = tbl[1][din_w[1]];

  decoder_bist_ctrl #(.SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .d_in_o(din_w[0]), .d_out_i(dout_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail_mask(mask_w[0]),
    .fail_count(cnt_w[0]), .first_fail_code(ffc_w[0]), .first_fail_valid(ffv_w[0]),
    .onehot_err_count(oh_w[0]));

  decoder_bist_ctrl #(.SETTLE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .d_in_o(din_w[1]), .d_out_i(dout_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail_mask(mask_w[1]),
    .fail_count(cnt_w[1]), .first_fail_code(ffc_w[1]), .first_fail_valid(ffv_w[1]),
    .onehot_err_count(oh_w[1]));

  task automatic fill_good(input int s);
    for (int i = 0; i < 16; i++) tbl[s][i] = 16'd1 << i;
  endtask

  task automatic fill_bit2(input int s);
    for (int i = 0; i < 16; i++) tbl[s][i] = 16'd1 << ((i & 8) != 0 ? i : (i & 11));
  endtask

  // Reference: a response fails when it differs from the ideal decoder output for that code.
  task automatic model(input int s, output logic [15:0] m, output int c, output int f,
                       output logic fv, output int oh);
    m = '0; c = 0; f = 0; fv = 1'b0; oh = 0;
    for (int i = 0; i < 16; i++) begin
      if (tbl[s][i] !== (16'd1 << i)) begin
        m[i] = 1'b1;
        c++;
        if (!fv) begin f = i; fv = 1'b1; end
      end
      if ($countones(tbl[s][i]) != 1) oh++;
    end
`ifndef DECODER_BIST_ONEHOT_CHECK_EN
    oh = 0;
`endif
  endtask

  task automatic run(input int s, input bit extra, output int cyc, output int din_bad, output bit k0ok);
    int per;
    int lim;
    int want;
    per = (s == 0) ? 2 : 4;
    lim = 16 * per + 20;
    start_w[s] = 1'b1;
    @(posedge clk); #1;
    start_w[s] = 1'b0;
    k0ok = busy_w[s] && !done_w[s] && !pass_w[s] && mask_w[s] == 0 && cnt_w[s] == 0
           && !ffv_w[s] && oh_w[s] == 0 && din_w[s] == 0;
    din_bad = 0;
    cyc = lim + 1;
    for (int k = 1; k <= lim; k++) begin
      @(posedge clk); #1;
      want = (k / per > 15) ? 15 : k / per;
      if (din_w[s] != 4'(want)) din_bad++;
      start_w[s] = extra && (k == 5 || k == 40);
      if (done_w[s]) begin cyc = k; break; end
    end
    start_w[s] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_w = '0;
    fill_good(0);
    fill_good(1);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({busy_w[s], done_w[s], pass_w[s], ffv_w[s]} !== 4'b0) begin
        n_fail++; $display("FAIL reset_flags[%0d]: got busy/done/pass/ffv=%b want 0000", s,
                           {busy_w[s], done_w[s], pass_w[s], ffv_w[s]});
      end
      n_checks++;
      if ({din_w[s], mask_w[s], cnt_w[s], ffc_w[s], oh_w[s]} !== '0) begin
        n_fail++; $display("FAIL reset_values[%0d]: din=%h mask=%h cnt=%0d ffc=%0d oh=%0d want all 0", s,
                           din_w[s], mask_w[s], cnt_w[s], ffc_w[s], oh_w[s]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_correct;
    int cyc, bad;
    bit k0;
    fill_good(0);
    run(0, 1'b0, cyc, bad, k0);
    n_checks++;
    if (cyc != 32) begin n_fail++; $display("FAIL correct_latency: got %0d want 32", cyc); end
    n_checks++;
    if (!k0) begin n_fail++; $display("FAIL correct_start_state: got 0 want 1"); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL correct_din_seq: got %0d bad cycles want 0", bad); end
    n_checks++;
    if ({pass_w[0], busy_w[0], ffv_w[0]} !== 3'b100) begin
      n_fail++; $display("FAIL correct_flags: got pass/busy/ffv=%b want 100", {pass_w[0], busy_w[0], ffv_w[0]});
    end
    n_checks++;
    if (mask_w[0] !== 16'h0000 || cnt_w[0] !== 5'd0 || oh_w[0] !== 5'd0) begin
      n_fail++; $display("FAIL correct_results: got mask=%h cnt=%0d oh=%0d want 0000/0/0", mask_w[0], cnt_w[0], oh_w[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_w[0] !== 1'b1 || din_w[0] !== 4'd15) begin
      n_fail++; $display("FAIL correct_hold: got done=%b din=%0d want 1/15", done_w[0], din_w[0]);
    end
  endtask

  task automatic test_bit2_fault;
    int cyc, bad;
    bit k0;
    fill_bit2(0);
    run(0, 1'b0, cyc, bad, k0);
    n_checks++;
    if (cyc != 32) begin n_fail++; $display("FAIL bit2_latency: got %0d want 32", cyc); end
    n_checks++;
    if (pass_w[0] !== 1'b0 || mask_w[0] !== 16'h00F0 || cnt_w[0] !== 5'd4) begin
      n_fail++; $display("FAIL bit2_results: got pass=%b mask=%h cnt=%0d want 0/00f0/4", pass_w[0], mask_w[0], cnt_w[0]);
    end
    n_checks++;
    if (ffv_w[0] !== 1'b1 || ffc_w[0] !== 4'd4 || oh_w[0] !== 5'd0) begin
      n_fail++; $display("FAIL bit2_first: got ffv=%b ffc=%0d oh=%0d want 1/4/0", ffv_w[0], ffc_w[0], oh_w[0]);
    end
  endtask

  task automatic test_stuck_zero;
    int cyc, bad, oh_want;
    bit k0;
    for (int i = 0; i < 16; i++) tbl[0][i] = 16'h0000;
`ifdef DECODER_BIST_ONEHOT_CHECK_EN
    oh_want = 16;
`else
    oh_want = 0;
`endif
    run(0, 1'b0, cyc, bad, k0);
    n_checks++;
    if (!k0) begin n_fail++; $display("FAIL stuck_restart_clear: got 0 want 1"); end
    n_checks++;
    if (mask_w[0] !== 16'hFFFF || cnt_w[0] !== 5'd16 || pass_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL stuck_results: got mask=%h cnt=%0d pass=%b want ffff/16/0", mask_w[0], cnt_w[0], pass_w[0]);
    end
    n_checks++;
    if (ffc_w[0] !== 4'd0 || ffv_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL stuck_first: got ffc=%0d ffv=%b want 0/1", ffc_w[0], ffv_w[0]);
    end
    n_checks++;
    if (oh_w[0] !== 5'(oh_want)) begin n_fail++; $display("FAIL stuck_onehot: got %0d want %0d", oh_w[0], oh_want); end
  endtask

  task automatic test_settle3;
    int cyc, bad;
    bit k0;
    fill_good(1);
    run(1, 1'b1, cyc, bad, k0);
    n_checks++;
    if (cyc != 64) begin n_fail++; $display("FAIL settle3_latency: got %0d want 64", cyc); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL settle3_din_hold: got %0d bad cycles want 0", bad); end
    n_checks++;
    if (pass_w[1] !== 1'b1 || mask_w[1] !== 16'h0) begin
      n_fail++; $display("FAIL settle3_results: got pass=%b mask=%h want 1/0000", pass_w[1], mask_w[1]);
    end
    fill_bit2(1);
    run(1, 1'b1, cyc, bad, k0);
    n_checks++;
    if (cyc != 64 || bad != 0) begin n_fail++; $display("FAIL settle3_fault_timing: got cyc=%0d bad=%0d want 64/0", cyc, bad); end
    n_checks++;
    if (mask_w[1] !== 16'h00F0 || cnt_w[1] !== 5'd4 || ffc_w[1] !== 4'd4) begin
      n_fail++; $display("FAIL settle3_fault_results: got mask=%h cnt=%0d ffc=%0d want 00f0/4/4", mask_w[1], cnt_w[1], ffc_w[1]);
    end
  endtask

  task automatic test_async_reset;
    int cyc, bad, wait_k;
    bit k0;
    fill_bit2(0);
    start_w[0] = 1'b1;
    @(posedge clk); #1;
    start_w[0] = 1'b0;
    wait_k = 0;
    while (din_w[0] != 4'd7 && wait_k < 40) begin
      @(posedge clk); #1;
      wait_k++;
    end
    n_checks++;
    if (din_w[0] !== 4'd7) begin n_fail++; $display("FAIL async_reach7: got %0d want 7", din_w[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({din_w[0], mask_w[0], cnt_w[0], ffc_w[0], oh_w[0]} !== '0
        || {busy_w[0], done_w[0], pass_w[0], ffv_w[0]} !== 4'b0) begin
      n_fail++; $display("FAIL async_clear: got din=%0d mask=%h cnt=%0d busy=%b ffv=%b want all 0",
                         din_w[0], mask_w[0], cnt_w[0], busy_w[0], ffv_w[0]);
    end
    #2 rst_n = 1'b1;
    fill_good(0);
    run(0, 1'b0, cyc, bad, k0);
    n_checks++;
    if (cyc != 32 || pass_w[0] !== 1'b1 || mask_w[0] !== 16'h0) begin
      n_fail++; $display("FAIL async_rerun: got cyc=%0d pass=%b mask=%h want 32/1/0000", cyc, pass_w[0], mask_w[0]);
    end
  endtask

  task automatic test_x_and_restart;
    int cyc, bad;
    bit k0;
    fill_good(0);
    tbl[0][9] = 16'bx;
    run(0, 1'b0, cyc, bad, k0);
    n_checks++;
    if (mask_w[0] !== 16'h0200 || cnt_w[0] !== 5'd1 || ffc_w[0] !== 4'd9 || pass_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL xresp_results: got mask=%h cnt=%0d ffc=%0d pass=%b want 0200/1/9/0",
                         mask_w[0], cnt_w[0], ffc_w[0], pass_w[0]);
    end
    fill_good(0);
    run(0, 1'b0, cyc, bad, k0);
    n_checks++;
    if (!k0) begin n_fail++; $display("FAIL xresp_done_restart_clear: got 0 want 1"); end
    n_checks++;
    if (cyc != 32 || pass_w[0] !== 1'b1 || cnt_w[0] !== 5'd0) begin
      n_fail++; $display("FAIL xresp_rerun: got cyc=%0d pass=%b cnt=%0d want 32/1/0", cyc, pass_w[0], cnt_w[0]);
    end
  endtask

  task automatic test_random;
    int cyc, bad, c, f, oh, s;
    logic [15:0] m;
    logic fv;
    bit k0;
    for (int it = 0; it < 16; it++) begin
      s = it % 2;
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0: tbl[s][i] = 16'($urandom);
          1: tbl[s][i] = 16'd1 << $urandom_range(0, 15);
          default: tbl[s][i] = 16'd1 << i;
        endcase
      end
      model(s, m, c, f, fv, oh);
      run(s, 1'b0, cyc, bad, k0);
      n_checks++;
      if (cyc != 16 * (s == 0 ? 2 : 4) || bad != 0 || !k0) begin
        n_fail++; $display("FAIL rand%0d_timing: got cyc=%0d bad=%0d k0=%b want %0d/0/1", it, cyc, bad, k0, 16 * (s == 0 ? 2 : 4));
      end
      n_checks++;
      if (mask_w[s] !== m || cnt_w[s] !== 5'(c) || pass_w[s] !== (c == 0)) begin
        n_fail++; $display("FAIL rand%0d_results: got mask=%h cnt=%0d pass=%b want %h/%0d/%b",
                           it, mask_w[s], cnt_w[s], pass_w[s], m, c, c == 0);
      end
      n_checks++;
      if (ffv_w[s] !== fv || (fv && ffc_w[s] !== 4'(f)) || oh_w[s] !== 5'(oh)) begin
        n_fail++; $display("FAIL rand%0d_first: got ffv=%b ffc=%0d oh=%0d want %b/%0d/%0d",
                           it, ffv_w[s], ffc_w[s], oh_w[s], fv, f, oh);
      end
    end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_bit2_fault;
    test_stuck_zero;
    test_settle3;
    test_async_reset;
    test_x_and_restart;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decoder_bist_ctrl.md
Name: decoder_bist_ctrl

Overview:
Built-in self-test controller wrapped around a 4x16 one-hot decoder under test (DUT), including our fault-injected decoder variants. It drives every 4-bit code into the DUT's d_in, waits a settle time, and samples the DUT's d_out. It compares each response with the expected one-hot word and records the results: pass/fail, failing-code mask, fail count, and first failing code. The block sits directly upstream of the decoder, driving d_in, and directly downstream of it, consuming d_out.

Parameters:
- SETTLE_CYCLES, default 1: cycles each code is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a test run.
- d_in_o  output  4  code driven to the DUT's d_in; registered.
- d_out_i  input  16  DUT response (from d_out).
- busy  output  1  high while a run is in progress.
- done  output  1  high when results are valid; held until the next accepted start.
- pass  output  1  valid with done; 1 if every code matched.
- fail_mask  output  16  bit i set if code i mismatched.
- fail_count  output  5  number of mismatching codes, 0..16.
- first_fail_code  output  4  lowest code that mismatched; valid when first_fail_valid=1.
- first_fail_valid  output  1  at least one mismatch recorded.
- onehot_err_count  output  5  count of responses that are not exactly one-hot (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including d_in_o=0 and pass=0; internal code and wait counters 0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 -> clear all result registers; code=0; wait_cnt=0; go to SETTLE. busy=1 from the next cycle.
- SETTLE: d_in_o=code.
  - wait_cnt increments each cycle.
  - When wait_cnt==SETTLE_CYCLES-1, go to CHECK.
- CHECK: sample d_out_i for the current code.
  - Expected word = 16'h0001 << code.
  - Mismatch = (d_out_i !== expected). An X or Z bit is a mismatch in simulation.
  - On mismatch:
    - set fail_mask[code];
    - fail_count += 1;
    - if first_fail_valid==0, load first_fail_code=code and set first_fail_valid=1.
  - If code==15, go to DONE. Otherwise code += 1, wait_cnt=0, go to SETTLE.
- DONE:
  - busy=0, done=1, pass=(fail_count==0).
  - Results and d_in_o are held.
  - start=1 -> same action as in IDLE, which clears done in the next cycle.
- Latency: each code occupies SETTLE_CYCLES+1 cycles. done rises 16*(SETTLE_CYCLES+1) cycles after the edge that accepts start (32 cycles at the default).
- start while busy: ignored, no restart and no effect on results.
- Code counter: stops at 15, no wrap. fail_count saturates naturally at 16 (5 bits).
- Reset mid-run: immediate return to IDLE with all outputs 0. Partial results are discarded.
- d_out_i is treated as combinational from d_in_o. One settle cycle is sufficient for a combinational DUT.

Optional Feature:
- Macro: DECODER_BIST_ONEHOT_CHECK_EN.
- Defined: in CHECK, onehot_err_count += 1 when d_out_i is zero or has two or more bits set. This is independent of the expected-value mismatch. The counter is cleared on start and held in DONE.
- Not defined: onehot_err_count is tied to 0 and no one-hot logic is synthesised. The port remains present.

Decomposition:
- Package decoder_bist_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE);
  - CODE_W=4, NUM_CODES=16, CNT_W=5.
- Sub-module decoder_bist_cmp (combinational):
  - inputs: code, response;
  - outputs: expected word, mismatch flag, onehot_ok flag.
- The FSM, counters and result registers remain in decoder_bist_ctrl.

Test Plan:
- Correct 4x16 decoder, default parameter, start pulse -> done at cycle 32; pass=1, fail_mask=16'h0000, fail_count=0, first_fail_valid=0.
- Decoder with d_in bit 2 forced to 0 whenever d_in[3]=0 -> pass=0, fail_mask=16'h00F0, fail_count=4, first_fail_code=4, first_fail_valid=1; onehot_err_count=0 with the macro defined.
- DUT output stuck at 16'h0000, macro defined -> fail_count=16, fail_mask=16'hFFFF, first_fail_code=0, onehot_err_count=16. Same stimulus with the macro undefined -> onehot_err_count=0.
- SETTLE_CYCLES=3 -> each d_in_o value is held 4 cycles; done at cycle 64. Extra start pulses at cycles 5 and 40 do not change timing or results.
- Assert rst_n=0 asynchronously while d_in_o=7 -> all outputs 0 immediately, state IDLE. After release, a new start completes normally in 32 cycles.
- DUT drives 16'bx for code 9 -> fail_mask[9]=1 and fail_count increments. After done, start in DONE clears the results and a rerun with a correct DUT gives pass=1.
